// File: rtl/fb_line_reader_pkg.sv
// rtl/fb_line_reader_pkg.sv - shared coordinate type and default geometry for the line reader
// Contents: screenXY (packed {x, y}), default H_RES/V_RES, coordinate field width CW.
package fb_line_reader_pkg;

    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;
    localparam int CW        = 10;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } screenXY;

endpackage

// File: rtl/fb_line_reader_if.sv
// rtl/fb_line_reader_if.sv - framebuffer read-port bundle between line reader and framebuffer
// master: reader side (drives rd_req/rd_coords, receives rd_grant/rd_valid/rd_data)
// slave:  framebuffer side
interface fb_line_reader_if;
    import fb_line_reader_pkg::*;

    logic       rd_req;
    screenXY    rd_coords;
    logic       rd_grant;
    logic       rd_valid;
    logic [2:0] rd_data;

    modport master (
        output rd_req,
        output rd_coords,
        input  rd_grant,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_coords,
        output rd_grant,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/fb_line_reader_line_bank_ram.sv
// rtl/fb_line_reader_line_bank_ram.sv - one line bank: DEPTH x 3-bit RAM, one write port, registered read
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later (0 when raddr >= DEPTH).
module line_bank_ram #(
    parameter int DEPTH = 320,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [2:0]    rdata
);

    logic [2:0] mem [DEPTH];
    logic [2:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= (raddr < AW'(DEPTH)) ? mem[raddr] : 3'd0;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fb_line_reader.sv
// rtl/fb_line_reader.sv - ping-pong scan-line prefetcher between framebuffer read port and VGA output
// Ports: Clk/Reset (async, active-high); new_frame, pix_coords, pix_active from the output path;
//        color_out (1-cycle latency); rd (framebuffer read master); line_ready; underrun (sticky).
module fb_line_reader
    import fb_line_reader_pkg::*;
#(
    parameter int H_RES    = H_RES_DEF,
    parameter int V_RES    = V_RES_DEF,
    parameter int READ_LAT = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             new_frame,
    input  screenXY          pix_coords,
    input  logic             pix_active,
    output logic [2:0]       color_out,
    fb_line_reader_if.master rd,
    output logic             line_ready,
    output logic             underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int OW = $clog2(READ_LAT + 2);
    localparam logic [CW-1:0] H_END = CW'(H_RES);
    localparam logic [CW:0]   V_END = (CW+1)'(V_RES);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] issue_x_q, issue_x_d;
    logic [CW-1:0] wr_x_q, wr_x_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] cur_y_q, cur_y_d;
    logic [OW-1:0] out_q, out_d;
    logic          disp_sel_q, disp_sel_d;
    logic          first_q, first_d;
    logic          line_ready_q, line_ready_d;
    logic          underrun_q, underrun_d;
    logic          pix_vld_q, pix_vld_d;
    logic          pix_sel_q, pix_sel_d;

    logic          rd_fire, ret, wr_en, advance, more_lines, restart;
    logic [CW:0]   next_y;
    logic [2:0]    rdata0, rdata1;

    assign rd.rd_req    = (state_q == ST_FILL) && (issue_x_q < H_END);
    assign rd.rd_coords = {issue_x_q, target_q};

    assign rd_fire    = rd.rd_req && rd.rd_grant;
    // A return with nothing outstanding is a framebuffer protocol error; ignore it.
    assign ret        = rd.rd_valid && (out_q != '0);
    assign out_d      = out_q + OW'(rd_fire) - OW'(ret);
    assign advance    = pix_active && !new_frame && (first_q || (pix_coords.y != cur_y_q));
    assign next_y     = {1'b0, pix_coords.y} + 1'b1;
    assign more_lines = next_y < V_END;
    assign restart    = new_frame || (advance && more_lines);
    // Returns landing on an abort cycle belong to the abandoned line.
    assign wr_en      = (state_q == ST_FILL) && ret && !new_frame && !advance && (wr_x_q < H_END);

    always_comb begin
        state_d      = state_q;
        issue_x_d    = issue_x_q;
        wr_x_d       = wr_x_q;
        target_d     = target_q;
        cur_y_d      = cur_y_q;
        disp_sel_d   = disp_sel_q;
        first_d      = first_q;
        line_ready_d = line_ready_q;
        underrun_d   = underrun_q;

        case (state_q)
            ST_FILL: begin
                if (rd_fire) begin
                    issue_x_d = issue_x_q + 1'b1;
                end
                if (wr_en) begin
                    wr_x_d = wr_x_q + 1'b1;
                    if (wr_x_d == H_END) begin
                        line_ready_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_d == '0) begin
                    state_d   = ST_FILL;
                    issue_x_d = '0;
                    wr_x_d    = '0;
                end
            end
            default: ;
        endcase

        if (new_frame) begin
            underrun_d = 1'b0;
            disp_sel_d = 1'b1;
            first_d    = 1'b1;
        end else if (advance) begin
            disp_sel_d   = ~disp_sel_q;
            cur_y_d      = pix_coords.y;
            first_d      = 1'b0;
            line_ready_d = 1'b0;
            if (!line_ready_q) begin
                underrun_d = 1'b1;
            end
            if (!more_lines) begin
                state_d   = ST_IDLE;
                issue_x_d = '0;
                wr_x_d    = '0;
            end
        end

        // Any reads still in flight must come back before the new line may be requested,
        // otherwise their data would be mistaken for the new line's first pixels.
        if (restart) begin
            target_d     = new_frame ? '0 : next_y[CW-1:0];
            line_ready_d = 1'b0;
            issue_x_d    = '0;
            wr_x_d       = '0;
            state_d      = (out_d != '0) ? ST_DRAIN : ST_FILL;
        end
    end

    // The swap cycle's own pixel is already read from the bank being swapped in.
    assign pix_vld_d = pix_active && (pix_coords.x < H_END);
    assign pix_sel_d = advance ? ~disp_sel_q : disp_sel_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            issue_x_q    <= '0;
            wr_x_q       <= '0;
            target_q     <= '0;
            cur_y_q      <= '0;
            out_q        <= '0;
            disp_sel_q   <= 1'b0;
            first_q      <= 1'b0;
            line_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
            pix_vld_q    <= 1'b0;
            pix_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_x_q    <= issue_x_d;
            wr_x_q       <= wr_x_d;
            target_q     <= target_d;
            cur_y_q      <= cur_y_d;
            out_q        <= out_d;
            disp_sel_q   <= disp_sel_d;
            first_q      <= first_d;
            line_ready_q <= line_ready_d;
            underrun_q   <= underrun_d;
            pix_vld_q    <= pix_vld_d;
            pix_sel_q    <= pix_sel_d;
        end
    end

    // Fill bank is always the one not selected for display.
    line_bank_ram #(.DEPTH(H_RES), .AW(AW)) u_bank0 (
        .clk   (Clk),
        .we    (wr_en && disp_sel_q),
        .waddr (wr_x_q[AW-1:0]),
        .wdata (rd.rd_data),
        .raddr (pix_coords.x[AW-1:0]),
        .rdata (rdata0)
    );

    line_bank_ram #(.DEPTH(H_RES), .AW(AW)) u_bank1 (
        .clk   (Clk),
        .we    (wr_en && !disp_sel_q),
        .waddr (wr_x_q[AW-1:0]),
        .wdata (rd.rd_data),
        .raddr (pix_coords.x[AW-1:0]),
        .rdata (rdata1)
    );

    assign color_out  = pix_vld_q ? (pix_sel_q ? rdata1 : rdata0) : 3'd0;
    assign line_ready = line_ready_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_fb_line_reader.sv
// tb/tb_fb_line_reader.sv - self-checking bench for fb_line_reader with a latency-2 framebuffer model
module tb_fb_line_reader;
    import fb_line_reader_pkg::*;

    localparam int H  = 320;
    localparam int V  = 240;
    localparam int RL = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       new_frame;
    screenXY    pix_coords;
    logic       pix_active;
    logic [2:0] color_out;
    logic       line_ready;
    logic       underrun;

    fb_line_reader_if rd_if ();

    fb_line_reader #(.H_RES(H), .V_RES(V), .READ_LAT(RL)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .new_frame  (new_frame),
        .pix_coords (pix_coords),
        .pix_active (pix_active),
        .color_out  (color_out),
        .rd         (rd_if),
        .line_ready (line_ready),
        .underrun   (underrun)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Framebuffer model: pixel (x, y) holds (x + y) mod 8, returned RL cycles after the grant.
    int      grant_mode = 0;
    bit      check_stab = 1'b0;
    int      stab_err   = 0;
    int      max_out    = 0;
    int      outst      = 0;
    int      ret_cnt    = 0;
    logic    grant_b;
    logic    p0_v = 1'b0, p1_v = 1'b0;
    logic [2:0] p0_d = 3'd0, p1_d = 3'd0;
    logic    prev_pend = 1'b0;
    screenXY prev_coords = '0;

    always @(negedge Clk) begin
        if (Reset) begin
            p0_v = 1'b0;
            p1_v = 1'b0;
            rd_if.rd_valid = 1'b0;
            rd_if.rd_grant = 1'b0;
            rd_if.rd_data  = 3'd0;
            outst     = 0;
            prev_pend = 1'b0;
        end else begin
            rd_if.rd_valid = p1_v;
            rd_if.rd_data  = p1_d;
            if (p1_v) begin
                ret_cnt++;
                outst--;
            end
            p1_v = p0_v;
            p1_d = p0_d;
            if (check_stab && prev_pend && (!rd_if.rd_req || rd_if.rd_coords != prev_coords))
                stab_err++;
            if (grant_mode == 0)      grant_b = 1'b1;
            else if (grant_mode == 1) grant_b = 1'($urandom_range(0, 1));
            else                      grant_b = 1'b0;
            rd_if.rd_grant = grant_b;
            p0_v = rd_if.rd_req && grant_b;
            p0_d = 3'(int'(rd_if.rd_coords.x) + int'(rd_if.rd_coords.y));
            if (p0_v) outst++;
            if (outst > max_out) max_out = outst;
            prev_pend   = rd_if.rd_req && !grant_b;
            prev_coords = rd_if.rd_coords;
        end
    end

    task automatic set_pix(input int x, input int y, input logic act);
        pix_coords.x = CW'(x);
        pix_coords.y = CW'(y);
        pix_active   = act;
    endtask

    task automatic sweep(input int y);
        for (int x = 0; x <= H; x++) begin
            @(negedge Clk);
            if (x > 0) check($sformatf("line%0d_px%0d", y, x - 1), int'(color_out), (x - 1 + y) % 8);
            if (x < H) set_pix(x, y, 1'b1);
            else       pix_active = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k;
        k = 0;
        while (!line_ready && k < budget) begin
            @(negedge Clk);
            k++;
        end
        check(name, int'(line_ready), 1);
    endtask

    task automatic wait_req(input string name, input int budget);
        int k;
        k = 0;
        while (!rd_if.rd_req && k < budget) begin
            @(negedge Clk);
            k++;
        end
        check(name, int'(rd_if.rd_req), 1);
    endtask

    typedef struct {
        int   x;
        int   y;
        logic act;
        int   exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n;
        int cnt;
        int base;

        tbl[0] = '{x: 0,   y: 0, act: 1'b1, exp: 0};
        tbl[1] = '{x: 1,   y: 0, act: 1'b1, exp: 1};
        tbl[2] = '{x: 7,   y: 0, act: 1'b1, exp: 7};
        tbl[3] = '{x: 8,   y: 0, act: 1'b1, exp: 0};
        tbl[4] = '{x: 100, y: 0, act: 1'b1, exp: 4};
        tbl[5] = '{x: 319, y: 0, act: 1'b1, exp: 7};
        tbl[6] = '{x: 320, y: 0, act: 1'b1, exp: 0};
        tbl[7] = '{x: 330, y: 0, act: 1'b1, exp: 0};
        tbl[8] = '{x: 5,   y: 0, act: 1'b0, exp: 0};
        tbl[9] = '{x: 13,  y: 0, act: 1'b1, exp: 5};

        Reset      = 1'b1;
        new_frame  = 1'b0;
        pix_active = 1'b0;
        pix_coords = '0;
        repeat (3) @(negedge Clk);
        check("rst_color_out", int'(color_out), 0);
        check("rst_rd_req", int'(rd_if.rd_req), 0);
        check("rst_rd_coords", int'(rd_if.rd_coords), 0);
        check("rst_line_ready", int'(line_ready), 0);
        check("rst_underrun", int'(underrun), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Line 0 fill with grant held high.
        new_frame = 1'b1;
        @(negedge Clk);
        new_frame = 1'b0;
        n = 1;
        check("first_rd_req", int'(rd_if.rd_req), 1);
        check("first_rd_x", int'(rd_if.rd_coords.x), 0);
        check("first_rd_y", int'(rd_if.rd_coords.y), 0);
        while (!line_ready && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check("fill_latency", n, 323);

        // Display line 0 from the table; the swap launches the line 1 fill under random grants.
        grant_mode = 1;
        check_stab = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (i > 0) check($sformatf("tbl%0d_x%0d", i - 1, tbl[i-1].x), int'(color_out), tbl[i-1].exp);
            set_pix(tbl[i].x, tbl[i].y, tbl[i].act);
        end
        @(negedge Clk);
        check("tbl9_x13", int'(color_out), tbl[9].exp);
        pix_active = 1'b0;
        check("swap_clears_ready", int'(line_ready), 0);
        check("no_underrun_y0", int'(underrun), 0);

        wait_ready("line1_ready_random", 4000);
        check("coords_stable_ungranted", stab_err, 0);
        check("max_outstanding", max_out, RL);
        grant_mode = 0;
        check_stab = 1'b0;
        sweep(1);
        check("no_underrun_y1", int'(underrun), 0);

        // Late swap: advance to y=3 with only 200 returns of line 3 collected.
        wait_ready("line2_ready", 1000);
        @(negedge Clk);
        set_pix(0, 2, 1'b1);
        base = ret_cnt;
        @(negedge Clk);
        pix_active = 1'b0;
        n = 0;
        while ((ret_cnt - base) < 200 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check("no_underrun_y2", int'(underrun), 0);
        set_pix(0, 3, 1'b1);
        @(negedge Clk);
        pix_active = 1'b0;
        check("underrun_set", int'(underrun), 1);
        check("underrun_ready_low", int'(line_ready), 0);
        wait_req("line4_req", 20);
        check("line4_start_x", int'(rd_if.rd_coords.x), 0);
        check("line4_start_y", int'(rd_if.rd_coords.y), 4);

        // new_frame mid-fill with reads in flight: drain, then refetch line 0.
        repeat (50) @(negedge Clk);
        new_frame = 1'b1;
        @(negedge Clk);
        new_frame = 1'b0;
        check("nf_clears_underrun", int'(underrun), 0);
        check("drain_drops_req", int'(rd_if.rd_req), 0);
        wait_req("refetch_req", 20);
        check("refetch_x", int'(rd_if.rd_coords.x), 0);
        check("refetch_y", int'(rd_if.rd_coords.y), 0);
        wait_ready("refetch_ready", 1000);
        sweep(0);

        // Last line: no further fill until the next frame.
        @(negedge Clk);
        set_pix(5, V - 1, 1'b1);
        cnt = 0;
        @(negedge Clk);
        set_pix(330, V - 1, 1'b1);
        cnt += int'(rd_if.rd_req);
        @(negedge Clk);
        check("x330_black", int'(color_out), 0);
        pix_active = 1'b0;
        cnt += int'(rd_if.rd_req);
        repeat (400) begin
            @(negedge Clk);
            cnt += int'(rd_if.rd_req);
        end
        check("no_req_after_last_line", cnt, 0);
        new_frame = 1'b1;
        @(negedge Clk);
        new_frame = 1'b0;
        check("req_after_new_frame", int'(rd_if.rd_req), 1);

        // Reset in the middle of a fill.
        n = 0;
        while (!(rd_if.rd_req && rd_if.rd_coords.x == CW'(100)) && n < 500) begin
            @(negedge Clk);
            n++;
        end
        check("reached_issue_x100", int'(rd_if.rd_coords.x), 100);
        Reset = 1'b1;
        set_pix(3, 0, 1'b1);
        @(negedge Clk);
        check("midrst_rd_req", int'(rd_if.rd_req), 0);
        check("midrst_line_ready", int'(line_ready), 0);
        check("midrst_color_out", int'(color_out), 0);
        check("midrst_underrun", int'(underrun), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        pix_active = 1'b0;
        cnt = 0;
        repeat (400) begin
            @(negedge Clk);
            cnt += int'(rd_if.rd_req) + int'(line_ready);
        end
        check("quiet_after_reset", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
